// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues one imem request at a time,
// applies branch redirects and stalls, and hands fetched words to decode over valid/ready.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    input  logic        if_ready,
    output logic [31:0] pc
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    function automatic logic [31:0] align4(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic        r_if_valid;
    logic        w_if_valid_nxt;
    logic [31:0] r_if_pc;
    logic [31:0] w_if_pc_nxt;
    logic [31:0] r_if_inst;
    logic [31:0] w_if_inst_nxt;
    logic        w_req;
    logic [31:0] w_tgt;

    assign w_tgt = align4(br_target);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_if_valid <= 1'b0;
            r_if_pc    <= '0;
            r_if_inst  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_if_valid <= w_if_valid_nxt;
            r_if_pc    <= w_if_pc_nxt;
            r_if_inst  <= w_if_inst_nxt;
        end
    end

    // A redirect always wins; a granted-but-killed request must still be drained
    // so its response is never mistaken for the redirect target's instruction.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_if_valid_nxt = r_if_valid;
        w_if_pc_nxt    = r_if_pc;
        w_if_inst_nxt  = r_if_inst;
        w_req          = 1'b0;
        case (r_state)
            S_REQ: begin
                w_req = !stall && !rst;
                if (br_taken) begin
                    w_pc_nxt = w_tgt;
                    if (w_req && imem_gnt) begin
                        w_state_nxt = S_DRAIN;
                    end
                end else if (w_req && imem_gnt) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (br_taken) begin
                    w_pc_nxt    = w_tgt;
                    w_state_nxt = imem_rvalid ? S_REQ : S_DRAIN;
                end else if (imem_rvalid) begin
                    w_if_inst_nxt  = imem_rdata;
                    w_if_pc_nxt    = r_pc;
                    w_if_valid_nxt = 1'b1;
                    w_pc_nxt       = r_pc + 32'd4;
                    w_state_nxt    = S_HOLD;
                end
            end
            S_DRAIN: begin
                if (br_taken) begin
                    w_pc_nxt = w_tgt;
                end
                if (imem_rvalid) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_HOLD: begin
                if (br_taken) begin
                    w_pc_nxt       = w_tgt;
                    w_if_valid_nxt = 1'b0;
                    w_state_nxt    = S_REQ;
                end else if (r_if_valid && if_ready) begin
                    w_if_valid_nxt = 1'b0;
                    w_state_nxt    = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
    end

    assign imem_req  = w_req;
    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign if_valid  = r_if_valid;
    assign if_pc     = r_if_pc;
    assign if_inst   = r_if_inst;

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer that owns the architectural PC register and drives the next-PC path. It issues one instruction-memory request at a time and hands the fetched word plus its PC to decode over a valid/ready handshake. It applies branch/jump redirects produced by npc_gen (br_taken, target) and honours stalls from the hazard unit. It sits between npc_gen/execute, the instruction memory port and the decode stage.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- br_taken  in  1  redirect request, one-cycle pulse from execute; `ENABLE` = redirect.
- br_target  in  32  redirect target, i.e. npc from npc_gen; bits [1:0] ignored.
- stall  in  1  hazard stall; suppresses new fetch requests.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address, always 4-byte aligned.
- imem_gnt  in  1  request accepted in this cycle when imem_req=1.
- imem_rvalid  in  1  read data valid; exactly one per granted request, earliest the cycle after grant.
- imem_rdata  in  32  instruction word.
- if_valid  out  1  fetched instruction available to decode.
- if_pc  out  32  PC of if_inst.
- if_inst  out  32  fetched instruction.
- if_ready  in  1  decode accepts when if_valid=1 and if_ready=1.
- pc  out  32  current fetch PC, equal to imem_addr.

## Operation
- States: REQ (requesting pc), WAIT (granted, awaiting rvalid), DRAIN (granted request killed by redirect, awaiting its rvalid), HOLD (instruction held for decode).
- REQ: imem_req = !stall. On imem_req && imem_gnt, go to WAIT; on grant, pc/imem_addr holds the granted address until the response.
- WAIT: imem_req=0. On imem_rvalid, latch if_inst=imem_rdata and if_pc=pc, set if_valid=1, set pc=pc+4 (mod 2^32, wraps 0xFFFF_FFFC→0), go to HOLD.
- HOLD: imem_req=0; if_valid, if_pc and if_inst are stable. On if_valid && if_ready, clear if_valid and go to REQ.
- DRAIN: imem_req=0. On imem_rvalid, discard the data with no if_valid, then go to REQ. pc already holds the redirect target.
- Redirect (br_taken=1) has priority over stall, HOLD and normal sequencing. Next-cycle pc = {br_target[31:2],2'b00}.
  - From REQ with same-cycle grant: go to DRAIN, because the old address was granted.
  - From REQ without grant: stay in REQ. The address changes next cycle; the memory port tolerates an address change before grant.
  - From WAIT: go to DRAIN. A same-cycle rvalid counts as the drained response, so go to REQ instead.
  - From DRAIN: stay in DRAIN with the new target; a same-cycle rvalid goes to REQ.
  - From HOLD: clear if_valid next cycle (the instruction is flushed even if if_ready=1) and go to REQ.
- Stall affects only REQ, where it forces imem_req=0. In WAIT/DRAIN/HOLD the state still advances on rvalid/if_ready.
- imem_rvalid in REQ or HOLD is ignored, which covers stray responses after reset.

## Timing
- Reset (rst=1 at an edge): pc=RESET_PC, state=REQ, if_valid=0, if_pc=0, if_inst=0. imem_req is 0 while rst=1 and rises in the first cycle after release, unless stall=1.
- Reset overrides everything, including mid-WAIT/DRAIN. An outstanding response arriving afterwards is dropped.
- Best-case latency, with grant in cycle N and rvalid in N+1: if_valid=1 from N+2. With if_ready=1, the next request is in cycle N+3, giving 1 instruction per 3 cycles.
- Redirect at cycle N: imem_addr=target from N+1 in REQ. A flushed if_valid is 0 from N+1.
- Only one request is outstanding; imem_req is never high in WAIT, DRAIN or HOLD.

## Test plan
- Sequential fetch: RESET_PC=0, gnt same cycle, rvalid next cycle with 0x00000013, if_ready=1. Required: imem_addr 0x0, 0x4, 0x8 and if_pc 0x0, 0x4, 0x8, each if_inst=0x00000013, if_valid high 1 cycle in every 3.
- Redirect in HOLD: hold 0x4 with if_ready=0, pulse br_taken with br_target=0x100. Required: if_valid=0 next cycle, next imem_addr=0x100, next if_pc=0x100.
- Redirect in WAIT: after grant of 0x8, pulse br_taken with target 0x103, then rvalid with 0xDEADBEEF. Required: 0xDEADBEEF never appears with if_valid=1, next imem_addr=0x100.
- Stall and backpressure: stall=1 for 5 cycles in REQ gives imem_req=0 and pc unchanged; release gives the same address. if_ready=0 for 10 cycles gives if_pc/if_inst stable and no imem_req.
- Redirect with stall: stall=1 and br_taken=1 with target 0x200 in the same cycle. Required: pc=0x200 and imem_req=0 until stall drops.
- Reset mid-WAIT: assert rst one cycle while a response is pending, then deliver rvalid. Required: response dropped, if_valid=0, first imem_addr=RESET_PC. PC wrap: fetch at 0xFFFFFFFC gives next imem_addr=0x0.
